// File: rtl/pong_match_ctrl.sv
// Match controller for the ping-pong game: serve/rally/pause/end phases,
// two saturating score counters, configurable goal, win margin and serve rule.
module pong_match_ctrl #(
  parameter int unsigned GOAL_POINTS  = 7,
  parameter int unsigned WIN_BY       = 1,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned BALL_W       = 10,
  parameter int unsigned TIME_W       = 6,
  parameter int unsigned P1_BOARD_X   = 110,
  parameter int unsigned P2_BOARD_X   = 530,
  parameter int unsigned PAUSE_CYCLES = 50,
  parameter int unsigned SERVE_MODE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p1l,
  input  logic               p1r,
  input  logic               p2l,
  input  logic               p2r,
  input  logic [BALL_W-1:0]  ball_x,
  input  logic [TIME_W-1:0]  time_cnt,
  output logic [2:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic               point_pulse
);

  localparam logic [2:0] ST_SERVE1 = 3'd0;
  localparam logic [2:0] ST_SERVE2 = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_END    = 3'd3;
  localparam logic [2:0] ST_POINT  = 3'd4;

  localparam int unsigned CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [BALL_W-1:0]  P1_X      = BALL_W'(P1_BOARD_X);
  localparam logic [BALL_W-1:0]  P2_X      = BALL_W'(P2_BOARD_X);
  // Two guard bits so the lead comparison can never overflow.
  localparam logic [SCORE_W+1:0] GOAL_E    = (SCORE_W + 2)'(GOAL_POINTS);
  localparam logic [SCORE_W+1:0] WINBY_E   = (SCORE_W + 2)'(WIN_BY);

  logic [2:0]         state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         win_q, win_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               nsrv_q, nsrv_d;   // 0 = P1 serves next, 1 = P2
  logic               prev1_q, prev2_q;

  logic               s1, s2, p1_goal, p2_goal;
  logic [SCORE_W-1:0] p1_new, p2_new;
  logic [SCORE_W:0]   total;
  logic [1:0]         point_win, timeout_win;

  function automatic logic wins(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic [SCORE_W+1:0] ae, be;
    ae = {2'b00, a};
    be = {2'b00, b};
    return (ae >= GOAL_E) && (ae >= be + WINBY_E);
  endfunction

  // Serve edges, goal detection and the scores a point award would produce.
  always_comb begin
    s1      = (p1l | p1r) & ~prev1_q;
    s2      = (p2l | p2r) & ~prev2_q;
    p1_goal = ball_x > P2_X;
    p2_goal = ~p1_goal & (ball_x < P1_X);
    p1_new  = (p1_goal && p1_q != SCORE_MAX) ? p1_q + 1'b1 : p1_q;
    p2_new  = (p2_goal && p2_q != SCORE_MAX) ? p2_q + 1'b1 : p2_q;
    total   = {1'b0, p1_new} + {1'b0, p2_new};
    if (wins(p1_new, p2_new))      point_win = 2'b01;
    else if (wins(p2_new, p1_new)) point_win = 2'b10;
    else                           point_win = 2'b00;
    if (p1_q > p2_q)      timeout_win = 2'b01;
    else if (p2_q > p1_q) timeout_win = 2'b10;
    else                  timeout_win = 2'b11;
  end

  // Phase sequencing and score/winner bookkeeping.
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    nsrv_d  = nsrv_q;
    unique case (state_q)
      ST_SERVE1, ST_SERVE2: begin
        if (time_cnt == '0) begin
          state_d = ST_END;
          win_d   = timeout_win;
        end else if ((state_q == ST_SERVE1) ? s1 : s2) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (p1_goal || p2_goal) begin
          // A goal outranks a simultaneous timeout.
          state_d = ST_POINT;
          p1_d    = p1_new;
          p2_d    = p2_new;
          pulse_d = 1'b1;
          cnt_d   = CNT_LOAD;
          win_d   = point_win;
          nsrv_d  = (SERVE_MODE == 0) ? p1_goal : total[1];
        end else if (time_cnt == '0) begin
          state_d = ST_END;
          win_d   = timeout_win;
        end
      end
      ST_POINT: begin
        if (cnt_q == '0) begin
          if (win_q != 2'b00) state_d = ST_END;
          else                state_d = nsrv_q ? ST_SERVE2 : ST_SERVE1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_END: ;
      default: state_d = ST_SERVE1;
    endcase
  end

  // State registers; button history starts high so a held button cannot serve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SERVE1;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= 2'b00;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      nsrv_q  <= 1'b0;
      prev1_q <= 1'b1;
      prev2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      nsrv_q  <= nsrv_d;
      prev1_q <= p1l | p1r;
      prev2_q <= p2l | p2r;
    end
  end

  assign game_state  = state_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign winner      = win_q;
  assign point_pulse = pulse_q;

endmodule
